// File: rtl/matmul_operand_feeder_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// matmul_operand_feeder_pkg: shared widths and FSM encodings for the feeder.
// Rev 1.0
// ----------------------------------------------------------------------------
package matmul_operand_feeder_pkg;

    localparam int DEF_DW = 8;
    localparam int DEF_BW = 32;

    typedef logic [2:0] state_t;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_CLEAR = 3'd1;
    localparam logic [2:0] ST_FEED  = 3'd2;
    localparam logic [2:0] ST_DRAIN = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    // Width of a dimension field; a 1x1 array still needs a 1-bit field.
    function automatic int dim_width(input int max_dim);
        return (max_dim > 1) ? $clog2(max_dim) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/matmul_operand_feeder_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// matmul_operand_feeder_if: start/operand inputs and array-edge outputs.
// Rev 1.0
// ----------------------------------------------------------------------------
interface matmul_operand_feeder_if
    import matmul_operand_feeder_pkg::*;
#(
    parameter int DW = DEF_DW,
    parameter int BW = DEF_BW
);
    localparam int MAX_DIM = BW / DW;
    localparam int DIM_W   = dim_width(MAX_DIM);

    logic                    start_i;
    logic [DIM_W-1:0]        n_dim_i;
    logic [DIM_W-1:0]        k_dim_i;
    logic [DIM_W-1:0]        m_dim_i;
    logic [BW*MAX_DIM-1:0]   operand_a_i;
    logic [BW*MAX_DIM-1:0]   operand_b_i;
    logic [DW*MAX_DIM-1:0]   a_o;
    logic [MAX_DIM-1:0]      a_valid_o;
    logic [DW*MAX_DIM-1:0]   b_o;
    logic [MAX_DIM-1:0]      b_valid_o;
    logic                    clear_o;
    logic                    busy_o;
    logic                    done_o;

    modport master (
        output start_i, n_dim_i, k_dim_i, m_dim_i, operand_a_i, operand_b_i,
        input  a_o, a_valid_o, b_o, b_valid_o, clear_o, busy_o, done_o
    );

    modport slave (
        input  start_i, n_dim_i, k_dim_i, m_dim_i, operand_a_i, operand_b_i,
        output a_o, a_valid_o, b_o, b_valid_o, clear_o, busy_o, done_o
    );

endinterface
`default_nettype wire

// File: rtl/matmul_operand_feeder_skew_lane.sv
`default_nettype none
// ----------------------------------------------------------------------------
// matmul_skew_lane: picks element (t - lane) of one row and flags its validity.
// Rev 1.0
// ----------------------------------------------------------------------------
module matmul_skew_lane
    import matmul_operand_feeder_pkg::*;
#(
    parameter int DW      = DEF_DW,
    parameter int BW      = DEF_BW,
    parameter int MAX_DIM = BW / DW,
    parameter int DIM_W   = dim_width(MAX_DIM)
) (
    input  logic [DIM_W-1:0] lane,
    input  logic [DIM_W+1:0] t,
    input  logic [DIM_W-1:0] k_dim,
    input  logic             en,
    input  logic [BW-1:0]    row,
    output logic [DW-1:0]    elem,
    output logic             valid
);

    logic [DIM_W+1:0] lane_ext;
    logic [DIM_W+1:0] k_ext;
    logic [DIM_W+1:0] idx;
    logic [DIM_W-1:0] sel;
    logic             in_window;

    // t < lane must read as "not yet", so the window test guards the subtraction.
    always_comb begin
        lane_ext  = {2'b00, lane};
        k_ext     = {2'b00, k_dim};
        idx       = t - lane_ext;
        sel       = idx[DIM_W-1:0];
        in_window = (t >= lane_ext) && (idx <= k_ext);
        valid     = en && in_window;
        elem      = '0;
        if (valid) begin
            elem = row[DW*sel +: DW];
        end
    end

endmodule
`default_nettype wire

// File: rtl/matmul_operand_feeder.sv
`default_nettype none
// ----------------------------------------------------------------------------
// matmul_operand_feeder: snapshots A/B on start and streams them skewed into
// the systolic array edges, then drains and reports done. Rev 1.0
// ----------------------------------------------------------------------------
module matmul_operand_feeder
    import matmul_operand_feeder_pkg::*;
#(
    parameter int DW = DEF_DW,
    parameter int BW = DEF_BW
) (
    input  logic                     clk_i,
    input  logic                     reset_ni,
    matmul_operand_feeder_if.slave   bus
);

    localparam int MAX_DIM = BW / DW;
    localparam int DIM_W   = dim_width(MAX_DIM);
    localparam int TW      = DIM_W + 2;

    state_t                  state;
    logic [TW-1:0]           t;
    logic [BW*MAX_DIM-1:0]   a_snap;
    logic [BW*MAX_DIM-1:0]   b_snap;
    logic [DIM_W-1:0]        n_dim;
    logic [DIM_W-1:0]        k_dim;
    logic [DIM_W-1:0]        m_dim;

    logic [TW-1:0]           feed_last;
    logic [TW-1:0]           drain_last;
    logic                    feeding;

    logic [BW-1:0]           b_col   [MAX_DIM];
    logic [DW-1:0]           a_elem  [MAX_DIM];
    logic [DW-1:0]           b_elem  [MAX_DIM];
    logic [MAX_DIM-1:0]      a_valid;
    logic [MAX_DIM-1:0]      b_valid;

    always_comb begin
        feed_last  = {2'b00, k_dim} + TW'(MAX_DIM - 1);
        drain_last = TW'(MAX_DIM - 1);
        feeding    = (state == ST_FEED);
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state  <= ST_IDLE;
            t      <= '0;
            a_snap <= '0;
            b_snap <= '0;
            n_dim  <= '0;
            k_dim  <= '0;
            m_dim  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    t <= '0;
                    if (bus.start_i) begin
                        a_snap <= bus.operand_a_i;
                        b_snap <= bus.operand_b_i;
                        n_dim  <= bus.n_dim_i;
                        k_dim  <= bus.k_dim_i;
                        m_dim  <= bus.m_dim_i;
                        state  <= ST_CLEAR;
                    end
                end
                ST_CLEAR: begin
                    t     <= '0;
                    state <= bus.start_i ? ST_FEED : ST_IDLE;
                end
                ST_FEED: begin
                    if (!bus.start_i) begin
                        t     <= '0;
                        state <= ST_IDLE;
                    end else if (t == feed_last) begin
                        t     <= '0;
                        state <= ST_DRAIN;
                    end else begin
                        t <= t + 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (!bus.start_i) begin
                        t     <= '0;
                        state <= ST_IDLE;
                    end else if (t == drain_last) begin
                        t     <= '0;
                        state <= ST_DONE;
                    end else begin
                        t <= t + 1'b1;
                    end
                end
                ST_DONE: begin
                    t <= '0;
                    if (!bus.start_i) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    t     <= '0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Column c of B regrouped as one BW word so a B lane sees the same layout as an A row.
    for (genvar c = 0; c < MAX_DIM; c++) begin : g_bcol
        for (genvar k = 0; k < MAX_DIM; k++) begin : g_belem
            assign b_col[c][DW*k +: DW] = b_snap[BW*k + DW*c +: DW];
        end
    end

    for (genvar i = 0; i < MAX_DIM; i++) begin : g_lane
        logic a_en;
        logic b_en;

        assign a_en = feeding && (DIM_W'(i) <= n_dim);
        assign b_en = feeding && (DIM_W'(i) <= m_dim);

        matmul_skew_lane #(
            .DW      (DW),
            .BW      (BW),
            .MAX_DIM (MAX_DIM),
            .DIM_W   (DIM_W)
        ) u_a_lane (
            .lane  (DIM_W'(i)),
            .t     (t),
            .k_dim (k_dim),
            .en    (a_en),
            .row   (a_snap[BW*i +: BW]),
            .elem  (a_elem[i]),
            .valid (a_valid[i])
        );

        matmul_skew_lane #(
            .DW      (DW),
            .BW      (BW),
            .MAX_DIM (MAX_DIM),
            .DIM_W   (DIM_W)
        ) u_b_lane (
            .lane  (DIM_W'(i)),
            .t     (t),
            .k_dim (k_dim),
            .en    (b_en),
            .row   (b_col[i]),
            .elem  (b_elem[i]),
            .valid (b_valid[i])
        );
    end

    always_comb begin
        bus.a_o       = '0;
        bus.b_o       = '0;
        bus.a_valid_o = a_valid;
        bus.b_valid_o = b_valid;
        for (int i = 0; i < MAX_DIM; i++) begin
            bus.a_o[DW*i +: DW] = a_elem[i];
            bus.b_o[DW*i +: DW] = b_elem[i];
        end
        bus.clear_o = (state == ST_CLEAR);
        bus.busy_o  = (state != ST_IDLE);
        bus.done_o  = (state == ST_DONE);
    end

endmodule
`default_nettype wire

// File: tb/tb_matmul_operand_feeder.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_matmul_operand_feeder: directed vectors and corner-case sequences.
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_matmul_operand_feeder;

    logic clk;
    logic rst_n;

    matmul_operand_feeder_if #(.DW(8), .BW(32)) bus ();

    matmul_operand_feeder #(.DW(8), .BW(32)) dut (
        .clk_i    (clk),
        .reset_ni (rst_n),
        .bus      (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  n;
        logic [1:0]  k;
        logic [1:0]  m;
        int          t;
        logic [31:0] a;
        logic [3:0]  av;
        logic [31:0] b;
        logic [3:0]  bv;
    } vec_t;

    localparam logic [127:0] MAT_A = {32'h100F0E0D, 32'h0C0B0A09, 32'h08070605, 32'h04030201};
    localparam logic [127:0] MAT_B = {32'h44434241, 32'h34333231, 32'h24232221, 32'h14131211};

    vec_t vecs [10];
    int   vectors    = 0;
    int   miscompares = 0;
    int   a_cnt [4];
    int   b_cnt [4];
    int   clear_cnt;
    logic [3:0] a_seen;
    logic [3:0] b_seen;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check_idle_outputs(input string name);
        check({name, " a_o"},   bus.a_o, 32'h0);
        check({name, " b_o"},   bus.b_o, 32'h0);
        check({name, " valid"}, {24'h0, bus.a_valid_o, bus.b_valid_o}, 32'h0);
        check({name, " ctrl"},  {29'h0, bus.clear_o, bus.busy_o, bus.done_o}, 32'h0);
    endtask

    task automatic set_dims(input logic [1:0] n, input logic [1:0] k, input logic [1:0] m);
        bus.n_dim_i = n;
        bus.k_dim_i = k;
        bus.m_dim_i = m;
    endtask

    task automatic tally();
        for (int i = 0; i < 4; i++) begin
            a_cnt[i] += int'(bus.a_valid_o[i]);
            b_cnt[i] += int'(bus.b_valid_o[i]);
        end
        a_seen    |= bus.a_valid_o;
        b_seen    |= bus.b_valid_o;
        clear_cnt += int'(bus.clear_o);
    endtask

    // Starts from IDLE, one time unit after a rising edge; returns edges from the
    // sampling edge to done_o, leaving start_i high.
    task automatic run_op(input logic [1:0] n, input logic [1:0] k, input logic [1:0] m,
                          output int cyc);
        for (int i = 0; i < 4; i++) begin
            a_cnt[i] = 0;
            b_cnt[i] = 0;
        end
        a_seen = '0;
        b_seen = '0;
        clear_cnt = 0;
        set_dims(n, k, m);
        bus.start_i = 1'b1;
        @(posedge clk); #1;
        tally();
        cyc = 0;
        while (!bus.done_o && cyc < 60) begin
            @(posedge clk); #1;
            cyc++;
            tally();
        end
    endtask

    task automatic stop_op();
        bus.start_i = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        int cyc;
        int ones;
        int done_seen;

        vecs[0] = '{2'd3, 2'd3, 2'd3, 0, 32'h00000001, 4'b0001, 32'h00000011, 4'b0001};
        vecs[1] = '{2'd3, 2'd3, 2'd3, 1, 32'h00000502, 4'b0011, 32'h00001221, 4'b0011};
        vecs[2] = '{2'd3, 2'd3, 2'd3, 3, 32'h0D0A0704, 4'b1111, 32'h14233241, 4'b1111};
        vecs[3] = '{2'd3, 2'd3, 2'd3, 4, 32'h0E0B0800, 4'b1110, 32'h24334200, 4'b1110};
        vecs[4] = '{2'd3, 2'd3, 2'd3, 6, 32'h10000000, 4'b1000, 32'h44000000, 4'b1000};
        vecs[5] = '{2'd3, 2'd0, 2'd3, 2, 32'h00090000, 4'b0100, 32'h00130000, 4'b0100};
        vecs[6] = '{2'd1, 2'd3, 2'd2, 2, 32'h00000603, 4'b0011, 32'h00132231, 4'b0111};
        vecs[7] = '{2'd1, 2'd3, 2'd2, 3, 32'h00000704, 4'b0011, 32'h00233241, 4'b0111};
        vecs[8] = '{2'd3, 2'd1, 2'd3, 2, 32'h00090600, 4'b0110, 32'h00132200, 4'b0110};
        vecs[9] = '{2'd0, 2'd0, 2'd0, 0, 32'h00000001, 4'b0001, 32'h00000011, 4'b0001};

        rst_n           = 1'b0;
        bus.start_i     = 1'b0;
        bus.operand_a_i = MAT_A;
        bus.operand_b_i = MAT_B;
        set_dims(2'd3, 2'd3, 2'd3);
        repeat (2) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_idle_outputs("post-reset idle");

        // Table: observe one FEED cycle per record, then abort back to IDLE.
        for (int v = 0; v < 10; v++) begin
            set_dims(vecs[v].n, vecs[v].k, vecs[v].m);
            bus.start_i = 1'b1;
            repeat (vecs[v].t + 2) @(posedge clk);
            #1;
            check($sformatf("vec%0d a_o", v), bus.a_o, vecs[v].a);
            check($sformatf("vec%0d a_valid", v), {28'h0, bus.a_valid_o}, {28'h0, vecs[v].av});
            check($sformatf("vec%0d b_o", v), bus.b_o, vecs[v].b);
            check($sformatf("vec%0d b_valid", v), {28'h0, bus.b_valid_o}, {28'h0, vecs[v].bv});
            check($sformatf("vec%0d ctrl", v), {29'h0, bus.clear_o, bus.busy_o, bus.done_o}, 32'h2);
            stop_op();
            check($sformatf("vec%0d abort", v), {24'h0, bus.a_valid_o, bus.b_valid_o, 7'h0, bus.busy_o}, 32'h0);
        end

        // Reset in the middle of FEED, then a normal full run.
        set_dims(2'd3, 2'd3, 2'd3);
        bus.start_i = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("midfeed a_o", bus.a_o, 32'h00090603);
        #2 rst_n = 1'b0;
        #1;
        check_idle_outputs("async reset");
        bus.start_i = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_op(2'd3, 2'd3, 2'd3, cyc);
        check("latency 3x3x3", cyc, 12);
        check("clear pulses", clear_cnt, 1);
        check("a lanes seen", {28'h0, a_seen}, 32'hF);
        stop_op();
        check("idle after done", {30'h0, bus.busy_o, bus.done_o}, 32'h0);

        // k_dim = 0: every lane valid for exactly one cycle.
        run_op(2'd3, 2'd0, 2'd3, cyc);
        check("latency k=0", cyc, 9);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("k0 a_cnt%0d", i), a_cnt[i], 1);
            check($sformatf("k0 b_cnt%0d", i), b_cnt[i], 1);
        end
        stop_op();

        // Disabled rows/cols stay silent for the whole run.
        run_op(2'd1, 2'd3, 2'd2, cyc);
        check("latency n1m2", cyc, 12);
        check("n1 a_valid seen", {28'h0, a_seen}, 32'h3);
        check("m2 b_valid seen", {28'h0, b_seen}, 32'h7);
        check("n1 a_cnt0", a_cnt[0], 4);
        stop_op();

        // Operands and dims change during FEED; snapshot must be used.
        set_dims(2'd3, 2'd3, 2'd3);
        bus.start_i = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus.operand_a_i = '1;
        bus.operand_b_i = '1;
        set_dims(2'd0, 2'd0, 2'd0);
        repeat (3) @(posedge clk);
        #1;
        check("snapshot a_o", bus.a_o, 32'h0D0A0704);
        check("snapshot b_o", bus.b_o, 32'h14233241);
        cyc = 4;
        while (!bus.done_o && cyc < 60) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("latency snapshot", cyc, 12);
        ones = 0;
        repeat (16) begin
            @(posedge clk); #1;
            ones += int'(bus.done_o);
        end
        check("done held", ones, 16);
        stop_op();
        check("done drop", {30'h0, bus.busy_o, bus.done_o}, 32'h0);
        bus.operand_a_i = MAT_A;
        bus.operand_b_i = MAT_B;

        // Abort during DRAIN: no done, next start clears again.
        set_dims(2'd3, 2'd3, 2'd3);
        bus.start_i = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("drain outputs", {bus.a_o | bus.b_o}, 32'h0);
        check("drain ctrl", {24'h0, bus.a_valid_o, bus.b_valid_o, 5'h0, bus.clear_o, bus.busy_o, bus.done_o}, 32'h2);
        stop_op();
        check("drain abort", {30'h0, bus.busy_o, bus.done_o}, 32'h0);
        done_seen = 0;
        repeat (20) begin
            @(posedge clk); #1;
            done_seen += int'(bus.done_o);
        end
        check("no done after abort", done_seen, 0);
        bus.start_i = 1'b1;
        @(posedge clk); #1;
        check("restart clear", {31'h0, bus.clear_o}, 32'h1);
        stop_op();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
